// File: rtl/mshr_bus_sched.sv
// Issues dcache MSHR misses one at a time onto the L2 request bus (round-robin) and routes refills back per id.
// Optional macro MSHR_BUS_SCHED_PERF_EN adds saturating issue/stall performance counters.
module mshr_bus_sched #(
    parameter int MSHR_NUM        = 4,
    parameter int MSHR_NUM_LOG    = 2,
    parameter int PADDR_W         = 48,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [MSHR_NUM-1:0]           req_valid_vec,
    input  logic [MSHR_NUM*PADDR_W-1:0]   req_paddr_flat,
    output logic [MSHR_NUM-1:0]           req_grant_vec,
    output logic                          bus_valid,
    input  logic                          bus_ready,
    output logic [PADDR_W-1:0]            bus_paddr,
    output logic [MSHR_NUM_LOG-1:0]       bus_mshrid,
    input  logic                          bus_done,
    input  logic [MSHR_NUM_LOG-1:0]       bus_done_mshrid,
    input  logic [511:0]                  bus_read_data,
    output logic [MSHR_NUM-1:0]           resp_valid_vec,
    output logic [511:0]                  resp_data,
    output logic [MSHR_NUM-1:0]           inflight_vec,
    output logic [MSHR_NUM_LOG:0]         outstanding_cnt,
    output logic                          spurious_done
`ifdef MSHR_BUS_SCHED_PERF_EN
    ,
    output logic [31:0]                   perf_issue_cnt,
    output logic [31:0]                   perf_stall_cnt
`endif
);

    typedef enum logic {S_IDLE, S_HOLD} state_t;

    state_t                    r_state, w_state_nxt;
    logic [PADDR_W-1:0]        r_bus_paddr;
    logic [MSHR_NUM_LOG-1:0]   r_bus_mshrid;
    logic [MSHR_NUM-1:0]       r_inflight;
    logic [MSHR_NUM_LOG:0]     r_cnt;
    logic [MSHR_NUM_LOG-1:0]   r_rr;
    logic [MSHR_NUM-1:0]       r_resp_valid;
    logic [511:0]              r_resp_data;
    logic                      r_spurious;

    logic [MSHR_NUM-1:0]       w_held_oh, w_elig, w_fire_oh, w_done_oh;
    logic                      w_hold, w_fire, w_load, w_done_ok, w_found;
    logic [MSHR_NUM_LOG:0]     w_occupied;
    logic [MSHR_NUM_LOG-1:0]   w_pick;
    logic [PADDR_W-1:0]        w_sel_paddr;

    assign w_hold     = (r_state == S_HOLD);
    assign w_held_oh  = w_hold ? (MSHR_NUM'(1) << r_bus_mshrid) : '0;
    assign w_elig     = req_valid_vec & ~r_inflight & ~w_held_oh;
    assign w_fire     = w_hold & bus_ready;
    assign w_fire_oh  = w_fire ? w_held_oh : '0;
    // The held request already owns a slot, so it counts against the cap.
    assign w_occupied = r_cnt + (MSHR_NUM_LOG+1)'(w_hold);
    assign w_load     = (|w_elig) && (w_occupied < (MSHR_NUM_LOG+1)'(MAX_OUTSTANDING))
                        && (!w_hold || w_fire);
    assign w_done_ok  = bus_done & r_inflight[bus_done_mshrid];
    assign w_done_oh  = w_done_ok ? (MSHR_NUM'(1) << bus_done_mshrid) : '0;

    always_comb begin
        w_pick      = '0;
        w_found     = 1'b0;
        w_sel_paddr = '0;
        for (int k = 0; k < MSHR_NUM; k++) begin
            if (!w_found && w_elig[r_rr + MSHR_NUM_LOG'(k)]) begin
                w_pick  = r_rr + MSHR_NUM_LOG'(k);
                w_found = 1'b1;
            end
        end
        for (int k = 0; k < MSHR_NUM; k++) begin
            if (w_pick == MSHR_NUM_LOG'(k))
                w_sel_paddr = req_paddr_flat[k*PADDR_W +: PADDR_W];
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        req_grant_vec = '0;
        if (w_load && !reset)
            req_grant_vec = MSHR_NUM'(1) << w_pick;
        case (r_state)
            S_IDLE:  if (w_load) w_state_nxt = S_HOLD;
            S_HOLD:  if (w_fire && !w_load) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_bus_paddr  <= '0;
            r_bus_mshrid <= '0;
            r_inflight   <= '0;
            r_cnt        <= '0;
            r_rr         <= '0;
            r_resp_valid <= '0;
            r_resp_data  <= '0;
            r_spurious   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_bus_paddr  <= {w_sel_paddr[PADDR_W-1:6], 6'b0};
                r_bus_mshrid <= w_pick;
            end
            r_inflight <= (r_inflight | w_fire_oh) & ~w_done_oh;
            r_cnt      <= r_cnt + (MSHR_NUM_LOG+1)'(w_fire) - (MSHR_NUM_LOG+1)'(w_done_ok);
            if (w_fire)
                r_rr <= r_bus_mshrid + MSHR_NUM_LOG'(1);
            r_resp_valid <= w_done_oh;
            if (w_done_ok)
                r_resp_data <= bus_read_data;
            if (bus_done && !r_inflight[bus_done_mshrid])
                r_spurious <= 1'b1;
        end
    end

    assign bus_valid       = w_hold;
    assign bus_paddr       = r_bus_paddr;
    assign bus_mshrid      = r_bus_mshrid;
    assign resp_valid_vec  = r_resp_valid;
    assign resp_data       = r_resp_data;
    assign inflight_vec    = r_inflight;
    assign outstanding_cnt = r_cnt;
    assign spurious_done   = r_spurious;

`ifdef MSHR_BUS_SCHED_PERF_EN
    logic [31:0] r_perf_issue, r_perf_stall;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_perf_issue <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_fire && (r_perf_issue != '1))
                r_perf_issue <= r_perf_issue + 32'd1;
            if (w_hold && !bus_ready && (r_perf_stall != '1))
                r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign perf_issue_cnt = r_perf_issue;
    assign perf_stall_cnt = r_perf_stall;
`endif

endmodule
